word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial front end for the ones-counting FSM. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `ser_out`, which connects directly to the counter's serial `in` input. A one-entry holding register lets frames run back-to-back with no idle cycle between them. `ser_out` is forced to 0 when idle, so the downstream counter holds its value between frames. `frame_start` can drive a per-frame clear of the counter.

## Interface
Parameters:
- `WIDTH`, 8, word width in bits; legal range 2..64.
- `LSB_FIRST`, 1, 1 = bit 0 is shifted first; 0 = bit WIDTH-1 is shifted first.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  word to serialize; sampled on an accept.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block can take a word; equals !hold_full, with no combinational path from `in_valid`.
- `ser_out`  out  1  current serial bit; 0 when `ser_valid`=0.
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle.
- `frame_start`  out  1  high during the first bit of each frame.
- `frame_end`  out  1  high during the last bit of each frame.
- `busy`  out  1  shifter active or holding register full.

## Operation
- Accept occurs when `in_valid`=1 and `in_ready`=1 at a rising edge.
- Storage:
  - `shreg` (WIDTH bits) plus `bit_cnt` (clog2(WIDTH) bits).
  - State register `st`: IDLE or SHIFT.
  - Holding register `hold` with flag `hold_full`.
- IDLE behaviour:
  - All outputs except `in_ready` are 0.
  - On an accept, the word loads directly into `shreg` (it bypasses `hold`), `bit_cnt`=0, and the state goes to SHIFT.
- SHIFT behaviour:
  - `ser_out` shows the current bit: `shreg[0]` when LSB_FIRST=1, `shreg[WIDTH-1]` when LSB_FIRST=0.
  - `ser_valid`=1.
  - On each edge, `shreg` shifts toward the output bit and `bit_cnt` increments.
- Last bit (`bit_cnt`=WIDTH-1) selects the next action:
  - If `hold_full`=1: load `hold` into `shreg`, clear `hold_full`, set `bit_cnt`=0, stay in SHIFT.
  - Else, if an accept occurs on this edge: load `in_data` directly into `shreg`, set `bit_cnt`=0, stay in SHIFT.
  - Else: go to IDLE.
- An accept while in SHIFT, not on the last bit, and with `hold_full`=0 writes `in_data` into `hold` and sets `hold_full`=1.
- `in_ready`=0 whenever `hold_full`=1. No accept is possible then, so no word is ever dropped or overwritten.
- `frame_start` = `ser_valid` && `bit_cnt`==0.
- `frame_end` = `ser_valid` && `bit_cnt`==WIDTH-1.
- `busy` = (`st`==SHIFT) || `hold_full`.
- Input contents are not checked. Any WIDTH-bit pattern, including all zeros, is a valid frame.

## Timing
- Reset state: `st`=IDLE, `hold_full`=0, `bit_cnt`=0, `shreg`=0.
  - Outputs under reset: `ser_out`=0, `ser_valid`=0, `frame_start`=0, `frame_end`=0, `busy`=0.
  - `in_ready`=1 in the first cycle after reset deasserts.
  - `in_valid` is ignored while `reset`=1.
- Latency: a word accepted at edge E0 from IDLE presents bit k during the cycle after edge E0+k, for k = 0..WIDTH-1. The frame lasts exactly WIDTH cycles.
- Back-to-back: with `in_valid` held high continuously, `ser_valid` stays 1 indefinitely with no gap. Throughput is one word per WIDTH cycles.
- Last bit, `hold_full`=1, `in_valid`=1: there is no accept at that edge (`in_ready`=0). `hold` moves to `shreg` and `in_ready` returns to 1 in the next cycle.
- Reset mid-frame:
  - The remaining bits and `hold` contents are discarded.
  - Outputs read their reset values in the cycle after the reset edge.
  - No `frame_end` is emitted for the aborted frame.
- All outputs are registered or decoded from registers; none depends combinationally on `in_valid` or `in_data`.

## Test plan
- **Single word:** WIDTH=8, LSB_FIRST=1, one accept of 8'hB5 from IDLE.
  - `ser_out` over 8 cycles = 1,0,1,0,1,1,0,1.
  - `frame_start` is high in cycle 0 only; `frame_end` is high in cycle 7 only.
  - An attached counter reads 5.
  - `busy` falls after the frame.
- **MSB first:** LSB_FIRST=0, 8'hB5 → bits 1,0,1,1,0,1,0,1.
- **Back-to-back:** stream 8'hFF, 8'h00, 8'h0F with `in_valid` held high.
  - 24 consecutive `ser_valid` cycles with no gap.
  - `frame_start` pulses at cycles 0, 8, 16.
  - `in_ready` is low while `hold` is occupied.
- **Stall:** accept 8'hAA, then hold `in_valid`=1 with 8'h55 followed by 8'h33.
  - 8'h55 is taken into `hold` on the next edge, and `in_ready` drops to 0.
  - 8'h33 is accepted only in the cycle after 8'h55's first bit appears.
  - Both words are serialized intact, in order.
- **Reset mid-frame:** assert `reset` for 1 cycle at bit 3 of 8'hF0 while `hold`=8'h0F.
  - Next cycle: `ser_valid`=0, `busy`=0, `in_ready`=1.
  - A subsequent 8'h01 serializes correctly from bit 0.
- **Idle:** 20 cycles with `in_valid`=0 → `ser_out`=0 and `ser_valid`=0 throughout, and the attached counter is unchanged.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and shifts them out
// one bit per clock, with a one-entry holding register for gap-free back-to-back frames.
module word_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           r_st, w_st_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_d;
  logic [WIDTH-1:0] r_hold, w_hold_d;
  logic             r_hold_full, w_hold_full_d;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;

  // in_ready is a pure function of r_hold_full, so accept never loops back through outputs.
  assign w_accept  = in_valid && !r_hold_full;
  assign w_last    = (r_st == StShift) && (r_bit_cnt == CW'(WIDTH - 1));
  assign w_shifted = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]} : {r_shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st        <= StIdle;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_st        <= w_st_d;
      r_shreg     <= w_shreg_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_hold      <= w_hold_d;
      r_hold_full <= w_hold_full_d;
    end
  end

  always_comb begin
    w_st_d        = r_st;
    w_shreg_d     = r_shreg;
    w_bit_cnt_d   = r_bit_cnt;
    w_hold_d      = r_hold;
    w_hold_full_d = r_hold_full;
    unique case (r_st)
      StIdle: begin
        if (w_accept) begin
          w_shreg_d   = in_data;
          w_bit_cnt_d = '0;
          w_st_d      = StShift;
        end
      end
      StShift: begin
        if (w_last) begin
          w_bit_cnt_d = '0;
          if (r_hold_full) begin
            w_shreg_d     = r_hold;
            w_hold_full_d = 1'b0;
          end else if (w_accept) begin
            w_shreg_d = in_data;
          end else begin
            w_shreg_d = w_shifted;
            w_st_d    = StIdle;
          end
        end else begin
          w_shreg_d   = w_shifted;
          w_bit_cnt_d = r_bit_cnt + CW'(1);
          if (w_accept) begin
            w_hold_d      = in_data;
            w_hold_full_d = 1'b1;
          end
        end
      end
      default: w_st_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready    = !r_hold_full;
    ser_valid   = (r_st == StShift);
    ser_out     = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = (r_st == StShift) || r_hold_full;
    if (r_st == StShift) begin
      ser_out     = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
      frame_start = (r_bit_cnt == '0);
      frame_end   = w_last;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an LSB-first and an MSB-first instance share one
// stimulus stream; a small ones counter models the downstream consumer.
module tb_word_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;

  logic l_ready, l_ser, l_sval, l_fs, l_fe, l_busy;
  logic m_ready, m_ser, m_sval, m_fs, m_fe, m_busy;

  int checks;
  int errors;

  logic [7:0] ones_cnt;
  logic       cnt_clr;

  word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .ser_out(l_ser), .ser_valid(l_sval),
    .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy)
  );

  word_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .ser_out(m_ser), .ser_valid(m_sval),
    .frame_start(m_fs), .frame_end(m_fe), .busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ones counter fed by the LSB-first instance.
  always_ff @(posedge clk) begin
    if (cnt_clr) ones_cnt <= '0;
    else if (l_sval && l_ser) ones_cnt <= ones_cnt + 8'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sval"}, l_sval, 1'b0);
    check({tag, "_ser"}, l_ser, 1'b0);
    check({tag, "_fs"}, l_fs, 1'b0);
    check({tag, "_fe"}, l_fe, 1'b0);
    check({tag, "_busy"}, l_busy, 1'b0);
    check({tag, "_ready"}, l_ready, 1'b1);
    check({tag, "_m_sval"}, m_sval, 1'b0);
  endtask

  // Three words offered in a fixed schedule: w0 from idle, w1 on the next edge (into hold),
  // w2 held on the bus until its accept in the cycle after w1's first bit.
  task automatic stream3(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2);
    logic [7:0] words [3];
    logic [7:0] cur;
    logic       exp_ready;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    in_data  = w0;
    in_valid = 1'b1;
    tick();
    in_data = w1;
    for (int c = 0; c < 24; c++) begin
      cur       = words[c / 8];
      exp_ready = !((c % 8) != 0 && c < 16);
      check({tag, "_sval"}, l_sval, 1'b1);
      check({tag, "_ser"}, l_ser, cur[c % 8]);
      check({tag, "_mser"}, m_ser, cur[7 - (c % 8)]);
      check({tag, "_fs"}, l_fs, (c % 8) == 0);
      check({tag, "_fe"}, l_fe, (c % 8) == 7);
      check({tag, "_ready"}, l_ready, exp_ready);
      check({tag, "_busy"}, l_busy, 1'b1);
      tick();
      if (c == 0) in_data = w2;
      if (c == 8) in_valid = 1'b0;
    end
    check_idle({tag, "_after"});
  endtask

  initial begin
    logic [7:0] w;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    cnt_clr  = 1'b1;

    // Reset with in_valid high: must be ignored.
    tick();
    check_idle("rst_hold");
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_idle("rst_exit");
    cnt_clr = 1'b0;

    // Single word 8'hB5 from idle, both bit orders.
    w        = 8'hB5;
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check("single_sval", l_sval, 1'b1);
      check("single_ser", l_ser, w[k]);
      check("single_mser", m_ser, w[7 - k]);
      check("single_fs", l_fs, k == 0);
      check("single_fe", l_fe, k == 7);
      check("single_mfs", m_fs, k == 0);
      check("single_mfe", m_fe, k == 7);
      check("single_busy", l_busy, 1'b1);
      check("single_ready", l_ready, 1'b1);
      tick();
    end
    check_idle("single_end");
    check("single_count", ones_cnt, 8'd5);

    // Idle: nothing moves, counter holds.
    for (int k = 0; k < 20; k++) begin
      check("idle_sval", l_sval, 1'b0);
      check("idle_ser", l_ser, 1'b0);
      tick();
    end
    check("idle_count", ones_cnt, 8'd5);

    stream3("b2b", 8'hFF, 8'h00, 8'h0F);
    stream3("stall", 8'hAA, 8'h55, 8'h33);

    // Reset at bit 3 of 8'hF0 with 8'h0F sitting in hold.
    in_data  = 8'hF0;
    in_valid = 1'b1;
    tick();
    in_data = 8'h0F;
    tick();
    in_valid = 1'b0;
    check("midrst_hold_full", l_ready, 1'b0);
    tick();
    tick();
    check("midrst_bit3_ser", l_ser, 1'b0);
    check("midrst_bit3_sval", l_sval, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst_after");
    tick();
    check_idle("midrst_idle");

    w        = 8'h01;
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("post_ser", l_ser, w[k]);
      check("post_mser", m_ser, w[7 - k]);
      check("post_fs", l_fs, k == 0);
      check("post_fe", l_fe, k == 7);
      tick();
    end
    check_idle("post_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
